// File: rtl/ifetch_queue.sv
// Instruction fetch stage: issues sequential word fetches, buffers returned
// instructions with their PCs, and supports redirect with stale-response drop.
module ifetch_queue #(
  parameter int INST_WIDTH = 16,
  parameter int PC_WIDTH   = 12,
  parameter int DEPTH      = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_mem_req,
  output logic [PC_WIDTH-1:0]   o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [INST_WIDTH-1:0] i_mem_rdata,
  output logic                  o_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_inst_pc,
  input  logic                  i_ready,
  input  logic                  i_redirect,
  input  logic [PC_WIDTH-1:0]   i_redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_CX = (CW + 1)'(DEPTH);

  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [PC_WIDTH-1:0]   rsp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         live;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_used;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];

  logic grant;
  logic rsp_fire;
  logic push;
  logic pop;

  // Every live request owns a FIFO slot, so a response can never find it full.
  assign live        = outstanding - discard;
  assign credit_used = {1'b0, fifo_count} + {1'b0, live};

  assign o_mem_req  = !i_rst && !i_redirect && (credit_used < DEPTH_CX) &&
                      (outstanding < DEPTH_C);
  assign o_mem_addr = fetch_pc;

  assign grant    = o_mem_req && i_mem_gnt;
  assign rsp_fire = i_mem_rvalid && (outstanding != '0);
  assign push     = rsp_fire && (discard == '0) && !i_redirect;

  assign o_valid   = !i_rst && (fifo_count != '0) && !i_redirect;
  assign o_inst    = inst_mem[rd_ptr];
  assign o_inst_pc = pc_mem[rd_ptr];
  assign pop       = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= PC_WIDTH'(RESET_PC);
      rsp_pc      <= PC_WIDTH'(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rsp_fire);
      if (i_redirect) begin
        fetch_pc   <= i_redirect_pc;
        rsp_pc     <= i_redirect_pc;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        // Everything still in flight after this cycle belongs to the old stream.
        discard    <= outstanding - CW'(rsp_fire);
      end else begin
        if (grant) fetch_pc <= fetch_pc + 1'b1;
        if (push) begin
          rsp_pc <= rsp_pc + 1'b1;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (rsp_fire && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      inst_mem[wr_ptr] <= i_mem_rdata;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order, fixed-latency memory model.
module tb_ifetch_queue;

  localparam int IW = 16;
  localparam int PW = 12;
  localparam int D  = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          o_mem_req;
  logic [PW-1:0] o_mem_addr;
  logic          i_mem_gnt;
  logic          i_mem_rvalid;
  logic [IW-1:0] i_mem_rdata;
  logic          o_valid;
  logic [IW-1:0] o_inst;
  logic [PW-1:0] o_inst_pc;
  logic          i_ready;
  logic          i_redirect;
  logic [PW-1:0] i_redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 1;
  int cyc   = 0;
  logic spur_next = 1'b0;
  logic drv_real  = 1'b0;
  logic [PW-1:0] q_addr[$];
  int            q_due[$];

  always #5 i_clk = ~i_clk;

  ifetch_queue #(.INST_WIDTH(IW), .PC_WIDTH(PW), .DEPTH(D), .RESET_PC(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_valid(o_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc), .i_ready(i_ready),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
  );

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {4'h5, a} ^ 16'h0a5c;
  endfunction

  // One clock: sample at negedge, advance the memory model just after posedge.
  task automatic tick();
    logic g, was_rst;
    logic [PW-1:0] ga;
    @(negedge i_clk);
    g = o_mem_req & i_mem_gnt;
    ga = o_mem_addr;
    was_rst = i_rst;
    n_cmp++;
    if (dut.fifo_count > D) begin
      n_bad++;
      $display("FAIL fifo_overflow: count %0d limit %0d", dut.fifo_count, D);
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (was_rst) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (drv_real) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (g) begin
        q_addr.push_back(ga);
        q_due.push_back(cyc + lat - 1);
      end
    end
    drv_real = 1'b0;
    if (spur_next) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 16'hdead;
    end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = mem_word(q_addr[0]);
      drv_real     = 1'b1;
    end else begin
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
    end
    spur_next = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_mem_gnt = 1'b0; i_ready = 1'b0;
    i_redirect = 1'b0; i_redirect_pc = '0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_mem_gnt = 1'b1; i_ready = 1'b1;
    i_redirect = 1'b0; i_redirect_pc = '0;
    tick();
    tick();
    #1;
    n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", o_mem_req); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_mem_addr !== 12'h000) begin n_bad++; $display("FAIL reset_addr: got %h want 000", o_mem_addr); end
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; i_mem_gnt = 1'b1; i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_cmp++; if (o_mem_req !== 1'b1) begin n_bad++; $display("FAIL stream_req c%0d: got %b want 1", k, o_mem_req); end
      n_cmp++; if (o_mem_addr !== PW'(k)) begin n_bad++; $display("FAIL stream_addr c%0d: got %h want %h", k, o_mem_addr, PW'(k)); end
      n_cmp++; if (o_valid !== (k >= 2)) begin n_bad++; $display("FAIL stream_valid c%0d: got %b want %b", k, o_valid, (k >= 2)); end
      if (k >= 2) begin
        n_cmp++; if (o_inst_pc !== PW'(k - 2)) begin n_bad++; $display("FAIL stream_pc c%0d: got %h want %h", k, o_inst_pc, PW'(k - 2)); end
        n_cmp++; if (o_inst !== mem_word(PW'(k - 2))) begin n_bad++; $display("FAIL stream_inst c%0d: got %h want %h", k, o_inst, mem_word(PW'(k - 2))); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int grants;
    do_reset();
    lat = 1; i_mem_gnt = 1'b1; i_ready = 1'b0;
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (o_mem_req && i_mem_gnt) begin
        n_cmp++; if (o_mem_addr !== PW'(grants)) begin n_bad++; $display("FAIL bp_addr c%0d: got %h want %h", k, o_mem_addr, PW'(grants)); end
        grants++;
      end
      if (k >= 4) begin
        n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_low c%0d: got %b want 0", k, o_mem_req); end
      end
      tick();
    end
    n_cmp++; if (grants != 4) begin n_bad++; $display("FAIL bp_grants: got %0d want 4", grants); end
    #1;
    n_cmp++; if (o_valid !== 1'b1 || o_inst_pc !== 12'h000) begin n_bad++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=000", o_valid, o_inst_pc); end
    n_cmp++; if (o_mem_addr !== 12'h004) begin n_bad++; $display("FAIL bp_fetch_pc: got %h want 004", o_mem_addr); end
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (o_valid !== 1'b1 || o_inst_pc !== PW'(k)) begin n_bad++; $display("FAIL bp_drain c%0d: got v=%b pc=%h want v=1 pc=%h", k, o_valid, o_inst_pc, PW'(k)); end
      n_cmp++; if (o_inst !== mem_word(PW'(k))) begin n_bad++; $display("FAIL bp_drain_inst c%0d: got %h want %h", k, o_inst, mem_word(PW'(k))); end
      tick();
    end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    lat = 3; i_mem_gnt = 1'b1; i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== PW'(k)) begin n_bad++; $display("FAIL rd_issue c%0d: got req=%b addr=%h want req=1 addr=%h", k, o_mem_req, o_mem_addr, PW'(k)); end
      tick();
    end
    i_redirect = 1'b1; i_redirect_pc = 12'h100;
    #1;
    n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL rd_req_in_redirect: got %b want 0", o_mem_req); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_in_redirect: got %b want 0", o_valid); end
    tick();
    i_redirect = 1'b0;
    #1;
    n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 12'h100) begin n_bad++; $display("FAIL rd_new_addr: got req=%b addr=%h want req=1 addr=100", o_mem_req, o_mem_addr); end
    for (int k = 4; k < 8; k++) begin
      if (k > 4) #1;
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rd_stale_dropped c%0d: got %b want 0", k, o_valid); end
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      #1;
      n_cmp++; if (o_valid !== 1'b1 || o_inst_pc !== 12'h100 + PW'(j)) begin n_bad++; $display("FAIL rd_out c%0d: got v=%b pc=%h want v=1 pc=%h", j + 8, o_valid, o_inst_pc, 12'h100 + PW'(j)); end
      n_cmp++; if (o_inst !== mem_word(12'h100 + PW'(j))) begin n_bad++; $display("FAIL rd_inst c%0d: got %h want %h", j + 8, o_inst, mem_word(12'h100 + PW'(j))); end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] e;
    do_reset();
    lat = 1; i_mem_gnt = 1'b1; i_ready = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 12'hffe;
    #1;
    n_cmp++; if (o_mem_req !== 1'b0 || o_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_redirect: got req=%b v=%b want 0 0", o_mem_req, o_valid); end
    tick();
    i_redirect = 1'b0;
    for (int k = 1; k < 7; k++) begin
      #1;
      if (k <= 4) begin
        e = 12'hffe + PW'(k - 1);
        n_cmp++; if (o_mem_addr !== e) begin n_bad++; $display("FAIL wrap_addr c%0d: got %h want %h", k, o_mem_addr, e); end
      end
      n_cmp++; if (o_valid !== (k >= 3)) begin n_bad++; $display("FAIL wrap_valid c%0d: got %b want %b", k, o_valid, (k >= 3)); end
      if (k >= 3) begin
        e = 12'hffe + PW'(k - 3);
        n_cmp++; if (o_inst_pc !== e || o_inst !== mem_word(e)) begin n_bad++; $display("FAIL wrap_out c%0d: got pc=%h inst=%h want pc=%h inst=%h", k, o_inst_pc, o_inst, e, mem_word(e)); end
      end
      tick();
    end
  endtask

  task automatic test_gnt_toggle();
    logic [9:0] gpat;
    logic [9:0] vpat;
    int exp_addr[10] = '{0, 1, 1, 1, 2, 3, 3, 3, 4, 5};
    int nd;
    gpat = 10'b11_1001_1001;
    vpat = 10'b10_0110_0100;
    do_reset();
    lat = 1; i_ready = 1'b1;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      i_mem_gnt = gpat[k];
      #1;
      n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== PW'(exp_addr[k])) begin n_bad++; $display("FAIL gnt_addr c%0d: got req=%b addr=%h want req=1 addr=%h", k, o_mem_req, o_mem_addr, PW'(exp_addr[k])); end
      n_cmp++; if (o_valid !== vpat[k]) begin n_bad++; $display("FAIL gnt_valid c%0d: got %b want %b", k, o_valid, vpat[k]); end
      if (o_valid) begin
        n_cmp++; if (o_inst_pc !== PW'(nd) || o_inst !== mem_word(PW'(nd))) begin n_bad++; $display("FAIL gnt_out c%0d: got pc=%h inst=%h want pc=%h", k, o_inst_pc, o_inst, PW'(nd)); end
        nd++;
      end
      tick();
    end
    n_cmp++; if (nd != 4) begin n_bad++; $display("FAIL gnt_delivered: got %0d want 4", nd); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    lat = 3; i_mem_gnt = 1'b1; i_ready = 1'b1;
    tick();
    tick();
    i_rst = 1'b1;
    #1;
    n_cmp++; if (o_mem_req !== 1'b0 || o_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_outputs: got req=%b v=%b want 0 0", o_mem_req, o_valid); end
    spur_next = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
    n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 12'h000) begin n_bad++; $display("FAIL midrst_restart: got req=%b addr=%h want req=1 addr=000", o_mem_req, o_mem_addr); end
    tick();
    for (int k = 4; k < 7; k++) begin
      #1;
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_spurious c%0d: got %b want 0", k, o_valid); end
      tick();
    end
    #1;
    n_cmp++; if (o_valid !== 1'b1 || o_inst_pc !== 12'h000 || o_inst !== mem_word(12'h000)) begin n_bad++; $display("FAIL midrst_first: got v=%b pc=%h inst=%h want v=1 pc=000 inst=%h", o_valid, o_inst_pc, o_inst, mem_word(12'h000)); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 1; i_mem_gnt = 1'b1; i_ready = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    #1;
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_full: got %b want 1", o_valid); end
    i_redirect = 1'b1; i_redirect_pc = 12'h200;
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_mem_req !== 1'b0) begin n_bad++; $display("FAIL b2b_first: got v=%b req=%b want 0 0", o_valid, o_mem_req); end
    tick();
    i_redirect_pc = 12'h300;
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_mem_req !== 1'b0) begin n_bad++; $display("FAIL b2b_second: got v=%b req=%b want 0 0", o_valid, o_mem_req); end
    tick();
    i_redirect = 1'b0; i_ready = 1'b1;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_flushed: got %b want 0", o_valid); end
    n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 12'h300) begin n_bad++; $display("FAIL b2b_addr: got req=%b addr=%h want req=1 addr=300", o_mem_req, o_mem_addr); end
    tick();
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_mem_addr !== 12'h301) begin n_bad++; $display("FAIL b2b_next: got v=%b addr=%h want v=0 addr=301", o_valid, o_mem_addr); end
    tick();
    #1;
    n_cmp++; if (o_valid !== 1'b1 || o_inst_pc !== 12'h300 || o_inst !== mem_word(12'h300)) begin n_bad++; $display("FAIL b2b_out: got v=%b pc=%h inst=%h want v=1 pc=300", o_valid, o_inst_pc, o_inst); end
    tick();
  endtask

  initial begin
    i_rst = 1'b1; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_wrap();
    test_gnt_toggle();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch stage that sits directly upstream of the cpu core. It generates sequential word addresses to instruction memory over a request/grant/response bus with variable latency. Returned instructions are buffered in a small prefetch FIFO and presented to the core with a valid/ready handshake, each tagged with its PC. A redirect input restarts fetch at a new PC, and responses still in flight at that point are discarded.

Parameters:
INST_WIDTH, 16, instruction word width
PC_WIDTH, 12, word-address/PC width; the address wraps modulo 2^PC_WIDTH
DEPTH, 4, prefetch FIFO entries; also the maximum number of outstanding requests (power of 2, >= 2)
RESET_PC, 0, fetch address after reset

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
o_mem_req  out  1  fetch request valid
o_mem_addr  out  PC_WIDTH  fetch word address
i_mem_gnt  in  1  memory accepts the request this cycle
i_mem_rvalid  in  1  response data valid (in order, at least 1 cycle after its grant)
i_mem_rdata  in  INST_WIDTH  response instruction word
o_valid  out  1  o_inst/o_inst_pc valid
o_inst  out  INST_WIDTH  instruction at FIFO head
o_inst_pc  out  PC_WIDTH  PC of o_inst
i_ready  in  1  core consumes the head entry
i_redirect  in  1  flush and restart fetch
i_redirect_pc  in  PC_WIDTH  new fetch PC

Behaviour:
- Clock is i_clk; reset is i_rst, synchronous, active-high.
- Reset clears the following state:
  - fetch_pc = rsp_pc = RESET_PC
  - FIFO empty
  - outstanding = discard = 0
- Reset output values:
  - While i_rst is high, o_mem_req = 0 and o_valid = 0.
  - o_mem_addr = RESET_PC.
  - o_inst and o_inst_pc are don't-care while o_valid = 0.
- Reset mid-operation: all in-flight requests are forgotten. Instruction memory shares i_rst. Any i_mem_rvalid seen while outstanding == 0 is ignored.
- Counters:
  - outstanding (0..DEPTH): total granted requests without a response.
  - discard (0..DEPTH, always <= outstanding): stale responses still to drop.
  - live = outstanding - discard.
- Request issue:
  - o_mem_req = !i_rst & !i_redirect & (fifo_count + live < DEPTH) & (outstanding < DEPTH).
  - o_mem_addr = fetch_pc, registered.
  - A grant occurs when o_mem_req & i_mem_gnt. On a grant, fetch_pc <= fetch_pc + 1 (wraps) and outstanding increments.
  - The credit rule guarantees the FIFO never overflows. The bench asserts this.
- Response handling on i_mem_rvalid with outstanding > 0: outstanding decrements, then one of:
  - If discard > 0: the data is dropped and discard decrements.
  - Otherwise: push {i_mem_rdata, rsp_pc} into the FIFO and rsp_pc <= rsp_pc + 1.
  - A grant and a response in the same cycle: outstanding is net unchanged.
- Output handshake:
  - o_valid = FIFO non-empty & !i_redirect. Head data is from registered storage; there is no bypass, so a push in cycle N is visible at N+1.
  - Pop when o_valid & i_ready.
  - A simultaneous push and pop when full is impossible because of the credit rule. When the FIFO is empty, push and pop cannot coincide.
- Redirect, in cycle R with i_redirect = 1, has priority over everything else:
  - FIFO cleared, and no pop occurs.
  - fetch_pc <= i_redirect_pc and rsp_pc <= i_redirect_pc.
  - No request is issued in cycle R.
  - A response arriving in cycle R is dropped.
  - discard <= outstanding after this cycle's response is accounted for, i.e. outstanding - (i_mem_rvalid ? 1 : 0).
  - A redirect while discard > 0 recomputes discard the same way, which is correct because every remaining outstanding response is stale.
  - The earliest request at the new PC is in cycle R+1.
- Latency with single-cycle memory (gnt = 1, rvalid at grant+1): request at cycle 0 after reset release, response at 1, o_valid at 2. Steady-state throughput is one instruction per cycle.
- Back-to-back redirects are legal; each restarts at its own target PC.

Test Plan:
- Reset release, gnt = 1, 1-cycle memory, i_ready = 1 -> o_mem_addr 0,1,2,... on consecutive cycles; o_valid first high at cycle 2; o_inst_pc 0,1,2,... one per cycle; o_inst equals memory contents.
- i_ready = 0 from reset, 1-cycle memory -> exactly 4 grants (addresses 0..3); o_mem_req then stays low; FIFO holds PCs 0..3. Raise i_ready -> PCs 0,1,2,3,4 delivered in order with no gap after the refill.
- 3-cycle memory latency, 3 outstanding, redirect to 0x100 -> the 3 stale responses are dropped; first o_valid after the redirect has o_inst_pc = 0x100 with the data of address 0x100.
- Redirect to 0xFFE (PC_WIDTH = 12) -> o_mem_addr FFE, FFF, 000, 001; o_inst_pc follows the same wrap.
- i_mem_gnt toggling 1,0,0,1 -> o_mem_addr held stable while ungranted; no duplicate or skipped PCs at the output.
- i_rst asserted with 2 requests outstanding, released after 1 cycle -> o_valid = 0 and o_mem_req = 0 during reset; fetch restarts at RESET_PC; the spurious rvalid with outstanding == 0 is ignored.
